wm8978_i2s_rx: RTL and testbench

- Captures ADC audio from the WM8978 in I2S format (BCLK, LRCK and ADCDAT are driven by the codec as master) and presents parallel left/right samples to the system-clock domain.
- Sits directly downstream of the WM8978 configuration stage.
- Stays idle until that stage reports cfg_done, so no samples are taken from an unconfigured codec.
- Oversamples the codec clocks with the system clock; no second clock domain is used.

---
 rtl/wm8978_i2s_rx.sv | 143 ++++++++++++++
 tb/tb_wm8978_i2s_rx.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm8978_i2s_rx.sv
// WM8978 I2S ADC receiver: oversamples the codec-driven BCLK/LRCK/ADCDAT with the
// system clock and delivers paired left/right samples once the codec is configured.
module wm8978_i2s_rx #(
  parameter int WL = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_done,
  input  logic          aud_bclk,
  input  logic          aud_lrc,
  input  logic          aud_adcdat,
  output logic [WL-1:0] left_data,
  output logic [WL-1:0] right_data,
  output logic          rx_done,
  output logic          frame_err
);

  localparam int CW = $clog2(WL + 1);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, WAIT} state_t;

  state_t          state_q;
  logic [2:0]      bclk_q;
  logic [1:0]      lrc_q;
  logic [1:0]      dat_q;
  logic            lrc_prev_q;
  logic            chan_q;
  logic            held_valid_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [WL-1:0]   shift_q;
  logic [WL-1:0]   held_q;
  logic [WL-1:0]   left_q;
  logic [WL-1:0]   right_q;
  logic            rx_done_q;
  logic            frame_err_q;

  logic            bclk_rise;
  logic            lrc_s;
  logic            dat_s;
  logic            lrc_edge;
  logic            word_last;
  logic [WL-1:0]   shift_d;
  logic [CW-1:0]   cnt_d;

  // Data shares the BCLK pipeline depth, so dat_s is the value present at the BCLK rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_q <= '0;
      lrc_q  <= '0;
      dat_q  <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], aud_bclk};
      lrc_q  <= {lrc_q[0], aud_lrc};
      dat_q  <= {dat_q[0], aud_adcdat};
    end
  end

  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lrc_s     = lrc_q[1];
  assign dat_s     = dat_q[1];
  assign lrc_edge  = lrc_s ^ lrc_prev_q;
  assign word_last = (bit_cnt_q == CW'(WL - 1));
  assign shift_d   = {shift_q[WL-2:0], dat_s};
  assign cnt_d     = bit_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lrc_prev_q   <= 1'b0;
      chan_q       <= 1'b0;
      held_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      held_q       <= '0;
      left_q       <= '0;
      right_q      <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (bclk_rise) lrc_prev_q <= lrc_s;
      if (!cfg_done) begin
        state_q      <= IDLE;
        bit_cnt_q    <= '0;
        held_valid_q <= 1'b0;
      end else if (bclk_rise) begin
        case (state_q)
          IDLE: state_q <= ARM;
          ARM: begin
            if (lrc_edge && !lrc_s) begin
              state_q   <= SHIFT;
              chan_q    <= 1'b0;
              bit_cnt_q <= '0;
            end
          end
          SHIFT: begin
            shift_q   <= shift_d;
            bit_cnt_q <= cnt_d;
            if (lrc_edge && !word_last) begin
              // Early LRCK edge: drop the partial word; a cut-short left word also voids the pair.
              frame_err_q <= 1'b1;
              if (!chan_q) held_valid_q <= 1'b0;
              chan_q    <= lrc_s;
              bit_cnt_q <= '0;
            end else if (word_last) begin
              if (!chan_q) begin
                held_q       <= shift_d;
                held_valid_q <= 1'b1;
              end else if (held_valid_q) begin
                left_q       <= held_q;
                right_q      <= shift_d;
                rx_done_q    <= 1'b1;
                held_valid_q <= 1'b0;
              end
              // Slot length equal to WL: the LSB shares its rise with the next channel's delay bit.
              if (lrc_edge) begin
                chan_q    <= lrc_s;
                bit_cnt_q <= '0;
              end else begin
                state_q <= WAIT;
              end
            end
          end
          WAIT: begin
            if (lrc_edge) begin
              state_q   <= SHIFT;
              chan_q    <= lrc_s;
              bit_cnt_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign left_data  = left_q;
  assign right_data = right_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_wm8978_i2s_rx.sv
// Bench for wm8978_i2s_rx: drives an I2S stream into a WL=32 and a WL=24 receiver and
// compares their pulses and samples against a slot-level model of the stream.
module tb_wm8978_i2s_rx;

  localparam int MAXP = 2048;
  localparam int MAXO = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfgDone;
  logic        bclk;
  logic        lrc;
  logic        dat;
  logic [31:0] left32, right32;
  logic [23:0] left24, right24;
  logic        rxDone32, rxDone24, frameErr32, frameErr24;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int riseStamp = 0;

  // Stream as transmitted, one entry per BCLK period, plus the slot list it was built from
  logic        lrcArr [MAXP];
  logic        datArr [MAXP];
  int          streamLen;
  int          slotCh [64];
  int          slotP  [64];
  int          slotS  [64];
  logic [31:0] slotV  [64];
  int          nSlots;

  // Observed (written by the monitor only) and expected results, index 0 = WL32, 1 = WL24
  logic [31:0] obsL [2][MAXO];
  logic [31:0] obsR [2][MAXO];
  int          obsLat [2][MAXO];
  int          obsN [2] = '{0, 0};
  int          obsErr [2] = '{0, 0};
  int          obsBase [2];
  int          errBase [2];
  logic [31:0] expL [2][64];
  logic [31:0] expR [2][64];
  int          expN [2];
  int          expErr [2];
  logic [31:0] lastL [2];
  logic [31:0] lastR [2];
  logic [31:0] snap [6];

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wm8978_i2s_rx #(.WL(32)) u32 (
    .clk(clk), .rst(rst), .cfg_done(cfgDone), .aud_bclk(bclk), .aud_lrc(lrc),
    .aud_adcdat(dat), .left_data(left32), .right_data(right32),
    .rx_done(rxDone32), .frame_err(frameErr32)
  );

  wm8978_i2s_rx #(.WL(24)) u24 (
    .clk(clk), .rst(rst), .cfg_done(cfgDone), .aud_bclk(bclk), .aud_lrc(lrc),
    .aud_adcdat(dat), .left_data(left24), .right_data(right24),
    .rx_done(rxDone24), .frame_err(frameErr24)
  );

  always @(negedge clk) begin
    if (rxDone32 && obsN[0] < MAXO) begin
      obsL[0][obsN[0]]   <= left32;
      obsR[0][obsN[0]]   <= right32;
      obsLat[0][obsN[0]] <= cyc - riseStamp;
      obsN[0]            <= obsN[0] + 1;
    end
    if (rxDone24 && obsN[1] < MAXO) begin
      obsL[1][obsN[1]]   <= {8'h00, left24};
      obsR[1][obsN[1]]   <= {8'h00, right24};
      obsLat[1][obsN[1]] <= cyc - riseStamp;
      obsN[1]            <= obsN[1] + 1;
    end
    if (frameErr32) obsErr[0] <= obsErr[0] + 1;
    if (frameErr24) obsErr[1] <= obsErr[1] + 1;
  end

  task automatic startScenario();
    streamLen = 0;
    nSlots = 0;
    for (int i = 0; i < MAXP; i++) begin
      lrcArr[i] = 1'b0;
      datArr[i] = 1'($urandom_range(0, 1));
    end
    for (int d = 0; d < 2; d++) begin
      obsBase[d] = obsN[d];
      errBase[d] = obsErr[d];
      expN[d] = 0;
      expErr[d] = 0;
    end
  endtask

  // A word's MSB follows the slot's first (delay) bit; its tail may spill into the next slot's first bit
  task automatic addSlot(input int ch, input int s, input logic [31:0] v);
    int p;
    p = streamLen;
    for (int i = 0; i < s; i++) lrcArr[p + i] = 1'(ch);
    for (int i = 0; i < 32; i++) datArr[p + 1 + i] = v[31 - i];
    slotCh[nSlots] = ch;
    slotP[nSlots] = p;
    slotS[nSlots] = s;
    slotV[nSlots] = v;
    nSlots++;
    streamLen += s;
  endtask

  // Receiver enabled at rise r (first left slot after r starts capture), disabled before rise f
  task automatic modelWindow(input int d, input int r, input int f);
    int w, p, s, e;
    bit started, valid;
    logic [31:0] held;
    w = (d == 0) ? 32 : 24;
    started = 0;
    valid = 0;
    held = '0;
    for (int j = 0; j < nSlots; j++) begin
      p = slotP[j];
      s = slotS[j];
      if (!started && slotCh[j] == 0 && p > r && p < f) started = 1;
      if (started) begin
        e = p + ((s < w) ? s : w);
        if (e >= f) break;
        if (s < w) begin
          expErr[d]++;
          if (slotCh[j] == 0) valid = 0;
        end else if (slotCh[j] == 0) begin
          held = slotV[j] >> (32 - w);
          valid = 1;
        end else if (valid) begin
          expL[d][expN[d]] = held;
          expR[d][expN[d]] = slotV[j] >> (32 - w);
          lastL[d] = expL[d][expN[d]];
          lastR[d] = expR[d][expN[d]];
          expN[d]++;
          valid = 0;
        end
      end
    end
  endtask

  // BCLK = clk/16; LRCK and data change with the BCLK falling edge
  task automatic playStream(input int r1, input int f1, input int r2, input int f2, input int rstIdx);
    for (int k = 0; k < streamLen; k++) begin
      @(negedge clk);
      bclk = 1'b0;
      lrc = lrcArr[k];
      dat = datArr[k];
      cfgDone = (k >= r1 && k < f1) || (k >= r2 && k < f2);
      if (k == rstIdx) begin
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        snap[0] = left32;  snap[1] = right32;
        snap[2] = {8'h00, left24};  snap[3] = {8'h00, right24};
        snap[4] = {30'd0, rxDone32, rxDone24};
        snap[5] = {30'd0, frameErr32, frameErr24};
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      bclk = 1'b1;
      riseStamp = cyc;
      repeat (7) @(negedge clk);
    end
    @(negedge clk);
    bclk = 1'b0;
    cfgDone = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfgDone = 1'b0; bclk = 1'b0; lrc = 1'b0; dat = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (left32 !== 32'd0 || right32 !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_data32: got %h/%h want 0/0", left32, right32);
    end
    checks++;
    if (left24 !== 24'd0 || right24 !== 24'd0) begin
      errors++; $display("[TB] FAIL reset_data24: got %h/%h want 0/0", left24, right24);
    end
    checks++;
    if ({rxDone32, rxDone24, frameErr32, frameErr24} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_pulses: got %b want 0000", {rxDone32, rxDone24, frameErr32, frameErr24});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      lastL[d] = '0;
      lastR[d] = '0;
    end
  endtask

  task automatic test_cfg_gating();
    startScenario();
    addSlot(1, 4, $urandom);
    for (int i = 0; i < 3; i++) begin
      addSlot(0, 32, $urandom);
      addSlot(1, 32, $urandom);
    end
    addSlot(0, 2, $urandom);
    playStream(0, 0, 0, 0, -1);
    checks++;
    if (obsN[0] + obsN[1] !== obsBase[0] + obsBase[1] || obsErr[0] + obsErr[1] !== errBase[0] + errBase[1]) begin
      errors++; $display("[TB] FAIL gated_pulses: got %0d pulses want 0", obsN[0] + obsN[1] + obsErr[0] + obsErr[1] - obsBase[0] - obsBase[1] - errBase[0] - errBase[1]);
    end
    checks++;
    if (left32 !== 32'd0 || right32 !== 32'd0 || left24 !== 24'd0 || right24 !== 24'd0) begin
      errors++; $display("[TB] FAIL gated_data: got %h/%h %h/%h want zeros", left32, right32, left24, right24);
    end
    startScenario();
    addSlot(1, 4, $urandom);
    for (int i = 0; i < 4; i++) begin
      addSlot(0, 32, $urandom);
      addSlot(1, 32, $urandom);
    end
    addSlot(0, 2, $urandom);
    for (int d = 0; d < 2; d++) modelWindow(d, slotP[2] + 10, streamLen);
    playStream(slotP[2] + 10, streamLen, 0, 0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsN[d] - obsBase[d] !== expN[d]) begin
        errors++; $display("[TB] FAIL gating_count dut%0d: got %0d want %0d", d, obsN[d] - obsBase[d], expN[d]);
      end
      for (int k = 0; k < expN[d] && k < obsN[d] - obsBase[d]; k++) begin
        checks++;
        if (obsL[d][obsBase[d] + k] !== expL[d][k] || obsR[d][obsBase[d] + k] !== expR[d][k]) begin
          errors++; $display("[TB] FAIL gating_pair dut%0d #%0d: got %h/%h want %h/%h", d, k, obsL[d][obsBase[d] + k], obsR[d][obsBase[d] + k], expL[d][k], expR[d][k]);
        end
      end
      checks++;
      if (obsErr[d] - errBase[d] !== expErr[d]) begin
        errors++; $display("[TB] FAIL gating_err dut%0d: got %0d want %0d", d, obsErr[d] - errBase[d], expErr[d]);
      end
    end
  endtask

  task automatic test_basic();
    startScenario();
    addSlot(1, 4, $urandom);
    for (int i = 0; i < 4; i++) begin
      addSlot(0, 32, 32'hA5A5_0001);
      addSlot(1, 32, 32'h5A5A_8000);
    end
    addSlot(0, 2, $urandom);
    for (int d = 0; d < 2; d++) modelWindow(d, 0, streamLen);
    playStream(0, streamLen, 0, 0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsN[d] - obsBase[d] !== expN[d]) begin
        errors++; $display("[TB] FAIL basic_count dut%0d: got %0d want %0d", d, obsN[d] - obsBase[d], expN[d]);
      end
      for (int k = 0; k < expN[d] && k < obsN[d] - obsBase[d]; k++) begin
        checks++;
        if (obsL[d][obsBase[d] + k] !== expL[d][k] || obsR[d][obsBase[d] + k] !== expR[d][k]) begin
          errors++; $display("[TB] FAIL basic_pair dut%0d #%0d: got %h/%h want %h/%h", d, k, obsL[d][obsBase[d] + k], obsR[d][obsBase[d] + k], expL[d][k], expR[d][k]);
        end
        checks++;
        if (obsLat[d][obsBase[d] + k] < 3 || obsLat[d][obsBase[d] + k] > 4) begin
          errors++; $display("[TB] FAIL basic_latency dut%0d #%0d: got %0d clk want 3..4", d, k, obsLat[d][obsBase[d] + k]);
        end
      end
      checks++;
      if (obsErr[d] - errBase[d] !== expErr[d]) begin
        errors++; $display("[TB] FAIL basic_err dut%0d: got %0d want %0d", d, obsErr[d] - errBase[d], expErr[d]);
      end
    end
    checks++;
    if (left32 !== 32'hA5A5_0001 || right32 !== 32'h5A5A_8000) begin
      errors++; $display("[TB] FAIL basic_hold32: got %h/%h want a5a50001/5a5a8000", left32, right32);
    end
  endtask

  task automatic test_wl24();
    startScenario();
    addSlot(1, 4, $urandom);
    for (int i = 0; i < 3; i++) begin
      addSlot(0, 32, {24'h123456, 8'($urandom)});
      addSlot(1, 32, {24'hFEDCBA, 8'($urandom)});
    end
    addSlot(0, 2, $urandom);
    for (int d = 0; d < 2; d++) modelWindow(d, 0, streamLen);
    playStream(0, streamLen, 0, 0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsN[d] - obsBase[d] !== expN[d]) begin
        errors++; $display("[TB] FAIL wl24_count dut%0d: got %0d want %0d", d, obsN[d] - obsBase[d], expN[d]);
      end
      for (int k = 0; k < expN[d] && k < obsN[d] - obsBase[d]; k++) begin
        checks++;
        if (obsL[d][obsBase[d] + k] !== expL[d][k] || obsR[d][obsBase[d] + k] !== expR[d][k]) begin
          errors++; $display("[TB] FAIL wl24_pair dut%0d #%0d: got %h/%h want %h/%h", d, k, obsL[d][obsBase[d] + k], obsR[d][obsBase[d] + k], expL[d][k], expR[d][k]);
        end
      end
    end
    checks++;
    if (left24 !== 24'h123456 || right24 !== 24'hFEDCBA) begin
      errors++; $display("[TB] FAIL wl24_hold: got %h/%h want 123456/fedcba", left24, right24);
    end
  endtask

  task automatic test_truncated();
    startScenario();
    addSlot(1, 4, $urandom);
    for (int i = 0; i < 4; i++) begin
      addSlot(0, (i == 1) ? 20 : 32, $urandom);
      addSlot(1, 32, $urandom);
    end
    addSlot(0, 2, $urandom);
    for (int d = 0; d < 2; d++) modelWindow(d, 0, streamLen);
    playStream(0, streamLen, 0, 0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsN[d] - obsBase[d] !== expN[d]) begin
        errors++; $display("[TB] FAIL trunc_count dut%0d: got %0d want %0d", d, obsN[d] - obsBase[d], expN[d]);
      end
      for (int k = 0; k < expN[d] && k < obsN[d] - obsBase[d]; k++) begin
        checks++;
        if (obsL[d][obsBase[d] + k] !== expL[d][k] || obsR[d][obsBase[d] + k] !== expR[d][k]) begin
          errors++; $display("[TB] FAIL trunc_pair dut%0d #%0d: got %h/%h want %h/%h", d, k, obsL[d][obsBase[d] + k], obsR[d][obsBase[d] + k], expL[d][k], expR[d][k]);
        end
      end
      checks++;
      if (obsErr[d] - errBase[d] !== expErr[d]) begin
        errors++; $display("[TB] FAIL trunc_err dut%0d: got %0d want %0d", d, obsErr[d] - errBase[d], expErr[d]);
      end
    end
  endtask

  task automatic test_dropout();
    int fall;
    startScenario();
    addSlot(1, 4, $urandom);
    for (int i = 0; i < 4; i++) begin
      addSlot(0, 32, $urandom);
      addSlot(1, 32, $urandom);
    end
    addSlot(0, 2, $urandom);
    fall = slotP[4] + 11;
    for (int d = 0; d < 2; d++) begin
      modelWindow(d, 0, fall);
      modelWindow(d, fall + 6, streamLen);
    end
    playStream(0, fall, fall + 6, streamLen, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsN[d] - obsBase[d] !== expN[d]) begin
        errors++; $display("[TB] FAIL dropout_count dut%0d: got %0d want %0d", d, obsN[d] - obsBase[d], expN[d]);
      end
      for (int k = 0; k < expN[d] && k < obsN[d] - obsBase[d]; k++) begin
        checks++;
        if (obsL[d][obsBase[d] + k] !== expL[d][k] || obsR[d][obsBase[d] + k] !== expR[d][k]) begin
          errors++; $display("[TB] FAIL dropout_pair dut%0d #%0d: got %h/%h want %h/%h", d, k, obsL[d][obsBase[d] + k], obsR[d][obsBase[d] + k], expL[d][k], expR[d][k]);
        end
      end
      checks++;
      if (obsErr[d] - errBase[d] !== expErr[d]) begin
        errors++; $display("[TB] FAIL dropout_err dut%0d: got %0d want %0d", d, obsErr[d] - errBase[d], expErr[d]);
      end
    end
    checks++;
    if (left32 !== lastL[0] || right32 !== lastR[0]) begin
      errors++; $display("[TB] FAIL dropout_hold32: got %h/%h want %h/%h", left32, right32, lastL[0], lastR[0]);
    end
  endtask

  task automatic test_back_to_back();
    startScenario();
    addSlot(1, 4, $urandom);
    for (int i = 0; i < 6; i++) begin
      addSlot(0, $urandom_range(18, 36), $urandom);
      addSlot(1, $urandom_range(18, 36), $urandom);
    end
    addSlot(0, 2, $urandom);
    for (int d = 0; d < 2; d++) modelWindow(d, 0, streamLen);
    playStream(0, streamLen, 0, 0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsN[d] - obsBase[d] !== expN[d]) begin
        errors++; $display("[TB] FAIL b2b_count dut%0d: got %0d want %0d", d, obsN[d] - obsBase[d], expN[d]);
      end
      for (int k = 0; k < expN[d] && k < obsN[d] - obsBase[d]; k++) begin
        checks++;
        if (obsL[d][obsBase[d] + k] !== expL[d][k] || obsR[d][obsBase[d] + k] !== expR[d][k]) begin
          errors++; $display("[TB] FAIL b2b_pair dut%0d #%0d: got %h/%h want %h/%h", d, k, obsL[d][obsBase[d] + k], obsR[d][obsBase[d] + k], expL[d][k], expR[d][k]);
        end
      end
      checks++;
      if (obsErr[d] - errBase[d] !== expErr[d]) begin
        errors++; $display("[TB] FAIL b2b_err dut%0d: got %0d want %0d", d, obsErr[d] - errBase[d], expErr[d]);
      end
    end
    checks++;
    if (left24 !== lastL[1][23:0] || right24 !== lastR[1][23:0]) begin
      errors++; $display("[TB] FAIL b2b_hold24: got %h/%h want %h/%h", left24, right24, lastL[1], lastR[1]);
    end
  endtask

  task automatic test_reset_mid();
    int rIdx;
    startScenario();
    addSlot(1, 4, $urandom);
    for (int i = 0; i < 4; i++) begin
      addSlot(0, 32, $urandom);
      addSlot(1, 32, $urandom);
    end
    addSlot(0, 2, $urandom);
    rIdx = slotP[3] + 13;
    for (int d = 0; d < 2; d++) begin
      modelWindow(d, 0, rIdx);
      lastL[d] = '0;
      lastR[d] = '0;
      modelWindow(d, rIdx, streamLen);
    end
    playStream(0, streamLen, 0, 0, rIdx);
    checks++;
    if (snap[0] !== 32'd0 || snap[1] !== 32'd0 || snap[2] !== 32'd0 || snap[3] !== 32'd0) begin
      errors++; $display("[TB] FAIL rstmid_data: got %h/%h %h/%h want zeros", snap[0], snap[1], snap[2], snap[3]);
    end
    checks++;
    if (snap[4] !== 32'd0 || snap[5] !== 32'd0) begin
      errors++; $display("[TB] FAIL rstmid_pulses: got %0d/%0d want 0/0", snap[4], snap[5]);
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obsN[d] - obsBase[d] !== expN[d]) begin
        errors++; $display("[TB] FAIL rstmid_count dut%0d: got %0d want %0d", d, obsN[d] - obsBase[d], expN[d]);
      end
      for (int k = 0; k < expN[d] && k < obsN[d] - obsBase[d]; k++) begin
        checks++;
        if (obsL[d][obsBase[d] + k] !== expL[d][k] || obsR[d][obsBase[d] + k] !== expR[d][k]) begin
          errors++; $display("[TB] FAIL rstmid_pair dut%0d #%0d: got %h/%h want %h/%h", d, k, obsL[d][obsBase[d] + k], obsR[d][obsBase[d] + k], expL[d][k], expR[d][k]);
        end
      end
      checks++;
      if (obsErr[d] - errBase[d] !== expErr[d]) begin
        errors++; $display("[TB] FAIL rstmid_err dut%0d: got %0d want %0d", d, obsErr[d] - errBase[d], expErr[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cfg_gating();
    test_basic();
    test_wl24();
    test_truncated();
    test_dropout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
